// File: rtl/lab1_imul_prod_accum.sv
// rtl/lab1_imul_prod_accum.sv - sums each group of p_nterms products into one signed 32-bit total
// Optional LAB1_IMUL_PROD_ACCUM_SAT_EN: signed-saturating adds with a sticky per-group overflow flag.
module lab1_imul_prod_accum #(
   parameter int p_nterms = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_val,
   output logic        in_rdy,
   input  logic [31:0] in_msg,
   output logic        out_val,
   input  logic        out_rdy,
   output logic [31:0] out_msg,
   output logic        out_ovf
);
   localparam int            CW       = (p_nterms > 1) ? $clog2(p_nterms) : 1;
   localparam logic [CW-1:0] LAST     = CW'(p_nterms - 1);
   localparam logic [0:0]    ST_ACCUM = 1'b0;
   localparam logic [0:0]    ST_DONE  = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   acc;
   logic [31:0]   sum;
   logic [31:0]   acc_next;
   logic          xfer;

   // Handshake outputs come only from registered state and reset.
   assign in_rdy  = !reset && (state == ST_ACCUM);
   assign out_val = !reset && (state == ST_DONE);
   assign out_msg = reset ? 32'd0 : acc;
   assign xfer    = in_val && in_rdy;
   assign sum     = acc + in_msg;

`ifdef LAB1_IMUL_PROD_ACCUM_SAT_EN
   logic sum_ovf;
   logic ovf;

   // Signed overflow: both operands share a sign that the wrapped sum does not.
   assign sum_ovf = (acc[31] == in_msg[31]) && (sum[31] != acc[31]);

   always_comb begin
      acc_next = sum;
      if (sum_ovf) begin
         acc_next = acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (xfer) begin
         ovf <= (cnt == '0) ? 1'b0 : (ovf | sum_ovf);
      end
   end

   assign out_ovf = out_val && ovf;
`else
   assign acc_next = sum;
   assign out_ovf  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_ACCUM;
         cnt   <= '0;
         acc   <= 32'd0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (xfer) begin
                  acc <= (cnt == '0) ? in_msg : acc_next;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= ST_DONE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: begin
               if (out_rdy) begin
                  state <= ST_ACCUM;
               end
            end
         endcase
      end
   end
endmodule
